inv_addkey_mixcol_stage: RTL

//  Pipelined stage directly downstream of the inverse SubBytes stage in the AES-128 decrypt datapath.

---
 rtl/aes_pkg.sv | 16 +
 rtl/inv_addkey_mixcol_stage_if.sv | 31 +++
 rtl/inv_mix_column_word.sv | 42 ++++
 rtl/inv_addkey_mixcol_stage.sv | 65 ++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES widths, state/column types and the GF(2^8) xtime helper
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W = 32;
    localparam logic [7:0] AES_RED_POLY = 8'h1B;

    typedef logic [AES_STATE_W-1:0] state_t;
    typedef logic [AES_COL_W-1:0] col_t;

    // Multiply by x in GF(2^8), reducing by 0x11B when the top bit falls out.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_addkey_mixcol_stage_if.sv
// rtl/inv_addkey_mixcol_stage_if.sv - valid/ready bus for the AddRoundKey + InvMixColumns stage
// Signals:
//   s_valid/s_ready/s_data/s_key/s_last : upstream state, round key and final-round flag
//   m_valid/m_ready/m_data/m_last       : downstream result state and final-round flag
// Modports:
//   slave  : the stage itself (consumes s_*, produces m_*)
//   master : the environment driving the stage
interface inv_addkey_mixcol_stage_if;
    import aes_pkg::*;

    logic   s_valid;
    logic   s_ready;
    state_t s_data;
    state_t s_key;
    logic   s_last;
    logic   m_valid;
    logic   m_ready;
    state_t m_data;
    logic   m_last;

    modport slave (
        input  s_valid, s_data, s_key, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_key, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/inv_mix_column_word.sv
// rtl/inv_mix_column_word.sv - combinational InvMixColumns on one 32-bit column
// Ports:
//   col   in  32  column [a0 a1 a2 a3], a0 in bits 31:24
//   mixed out 32  column [b0 b1 b2 b3], same layout
module inv_mix_column_word
    import aes_pkg::*;
(
    input  col_t col,
    output col_t mixed
);

    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    // x2/x4/x8 from chained xtime; the four constants are XOR combinations of them.
    always_comb begin
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
    end

    always_comb begin
        mixed = '0;
        for (int r = 0; r < 4; r++) begin
            mixed[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
    end

endmodule

// File: rtl/inv_addkey_mixcol_stage.sv
// rtl/inv_addkey_mixcol_stage.sv - two-register AddRoundKey then InvMixColumns stage (AES-128 decrypt)
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport: s_valid/s_ready/s_data/s_key/s_last in, m_valid/m_ready/m_data/m_last out
// S1 holds state^key, S2 holds the (optionally) mixed result that drives m_*.
module inv_addkey_mixcol_stage
    import aes_pkg::*;
(
    input logic clk,
    input logic rst,
    inv_addkey_mixcol_stage_if.slave bus
);

    state_t k1;
    logic   l1;
    logic   v1;
    state_t mix;
    logic   en1;
    logic   en2;

    // Per-stage enables; s_ready depends only on stage state and m_ready.
    assign en2 = !bus.m_valid || bus.m_ready;
    assign en1 = !v1 || en2;
    assign bus.s_ready = en1;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column_word u_imc (
            .col   (k1[127-32*c -: 32]),
            .mixed (mix[127-32*c -: 32])
        );
    end

    // S1: when enabled the register either takes new input or empties as it moves up.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en1) begin
            v1 <= bus.s_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en1 && bus.s_valid) begin
            k1 <= bus.s_data ^ bus.s_key;
            l1 <= bus.s_last;
        end
    end

    // S2: output register; holds while stalled, clears valid when drained with S1 empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
        end else if (en2) begin
            bus.m_valid <= v1;
            if (v1) begin
                bus.m_data <= l1 ? k1 : mix;
                bus.m_last <= l1;
            end
        end
    end

endmodule
